id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
- Registered RV32I decode stage, successor to the combinational ID block.
- Buffers fetched instructions in a parametrised FIFO and reads the regfile for the FIFO head.
- Generates the immediate and branch/JAL target, detects load-use hazards internally, and presents a registered ID/EX payload over a valid/ready handshake.
- Sits between IF and EX; flush is driven by EX redirect.

Parameters:
- XLEN, 32, datapath/PC width; immediates sign-extended to XLEN.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >=2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  EX redirect; kill all buffered and staged instructions
- if_valid_i  in  1  fetch entry valid
- if_ready_o  out  1  FIFO can accept (count < FIFO_DEPTH)
- if_inst_i  in  32  instruction word
- if_pc_i  in  XLEN  instruction PC
- rf_rs1_addr_o  out  5  regfile read addr, head inst[19:15]
- rf_rs2_addr_o  out  5  regfile read addr, head inst[24:20]
- rf_rs1_data_i  in  XLEN  combinational read data
- rf_rs2_data_i  in  XLEN  combinational read data
- wb_we_i  in  1  writeback enable (used by optional bypass)
- wb_rd_i  in  5  writeback register
- wb_data_i  in  XLEN  writeback data
- id_valid_o  out  1  ID/EX payload valid
- id_ready_i  in  1  EX accepts payload
- id_inst_o  out  32  staged instruction
- id_pc_o  out  XLEN  staged PC
- id_pc_plus_o  out  XLEN  staged PC+4
- id_imm_o  out  XLEN  sign-extended immediate
- id_rs1_data_o  out  XLEN  operand 1
- id_rs2_data_o  out  XLEN  operand 2
- id_rd_o  out  5  destination register
- id_target_o  out  XLEN  PC+imm for B-type/JAL, else 0
- hazard_stall_o  out  1  load-use bubble inserted this cycle

Behaviour:
- Reset: FIFO read/write pointers, count and all output registers cleared to 0; id_valid_o=0, hazard_stall_o=0, if_ready_o=1 one cycle after release.
- Push: if_valid_i && if_ready_o. if_ready_o derives from the registered count only. Push and pop in the same cycle are allowed when count < FIFO_DEPTH. No push occurs when full. Pointers wrap modulo FIFO_DEPTH.
- Head decode (combinational):
  - Opcode selects the immediate format: I (OP-IMM, LOAD, JALR), S, B, U (LUI, AUIPC), J (JAL), else 0.
  - rs1 is used by all except LUI/AUIPC/JAL.
  - rs2 is used by OP, STORE and BRANCH.
- Advance (pop head into output regs) when: head valid && !hazard && (!id_valid_o || id_ready_i).
- Latency: an instruction pushed into an empty FIFO in cycle N is presented on id_valid_o in cycle N+1 (minimum).
- Output hold: id_valid_o && !id_ready_i keeps all id_* outputs stable.
- Drain: if id_ready_i and nothing advances, id_valid_o drops to 0.
- Load-use hazard: the staged output is a valid LOAD, its rd != 0, and rd equals a used rs of the head, with id_ready_i=1.
  - Next cycle: id_valid_o=0 (bubble), head retained, hazard_stall_o=1 for that cycle.
  - The head advances on the following cycle.
- Flush: highest priority, synchronous.
  - Next cycle: FIFO count=0 and id_valid_o=0.
  - An if_valid_i push in the flush cycle is discarded.
  - hazard_stall_o is cleared.
- Arithmetic: PC+4 and target use XLEN-bit wrap-around with no overflow flag. id_rd_o is inst[11:7] regardless of type.
- Mid-operation reset asserts immediately (asynchronously), clears all state and drops any in-flight payload.

Optional Feature:
- Macro ID_WB_BYPASS_EN.
- Defined: at advance, if wb_we_i && wb_rd_i != 0 && wb_rd_i == rs1 (or rs2) of the head, capture wb_data_i instead of the regfile data for that operand. x0 always reads 0.
- Undefined: operands are taken straight from rf_*_data_i, and the regfile must be write-first.

Test Plan:
- Reset, then push ADDI x1,x0,5 at PC 0x0 -> next cycle id_valid_o=1, id_imm_o=5, id_pc_plus_o=0x4, id_rd_o=1.
- Push BEQ with offset -8 at PC 0x100 -> id_target_o=0xF8, id_imm_o=0xFFFFFFF8.
- LW x5,0(x2) followed by ADD x6,x5,x1 with id_ready_i=1 -> one bubble cycle (id_valid_o=0, hazard_stall_o=1), then the ADD is presented; ADD x6,x0,x1 gives no bubble.
- Hold id_ready_i=0 and push 3 instructions with FIFO_DEPTH=2 -> 1 staged, 2 buffered, if_ready_o=0, outputs stable; release -> in-order drain, one per cycle.
- Assert flush_i with a full FIFO and a simultaneous push -> next cycle id_valid_o=0, count=0; the pushed instruction never appears.
- With ID_WB_BYPASS_EN: regfile x3=1, wb_we_i=1, wb_rd_i=3, wb_data_i=0x55 at the advance of ADD x4,x3,x3 -> id_rs1_data_o=id_rs2_data_o=0x55; without the macro -> 1.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage: instruction FIFO, regfile read, immediate/target generation,
// load-use bubble insertion and a valid/ready ID/EX payload. Optional macro ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [4:0]      rf_rs1_addr_o,
  output logic [4:0]      rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     id_inst_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_pc_plus_o,
  output logic [XLEN-1:0] id_imm_o,
  output logic [XLEN-1:0] id_rs1_data_o,
  output logic [XLEN-1:0] id_rs2_data_o,
  output logic [4:0]      id_rd_o,
  output logic [XLEN-1:0] id_target_o,
  output logic            hazard_stall_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [31:0]      inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0]  pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [FIFO_DEPTH-1:0] wr_en;

  logic [31:0]      id_inst_reg;
  logic [XLEN-1:0]  id_pc_reg, id_pc_plus_reg, id_imm_reg;
  logic [XLEN-1:0]  id_rs1_reg, id_rs2_reg, id_target_reg;
  logic [4:0]       id_rd_reg;
  logic             id_valid_reg, hazard_stall_reg;

  logic             fifo_empty, push, pop, advance, hazard, head_valid;
  logic [31:0]      head_inst;
  logic [XLEN-1:0]  head_pc, head_imm, head_target, head_rs1_val, head_rs2_val;
  logic [4:0]       head_rs1, head_rs2;
  logic [6:0]       head_opc;
  logic signed [31:0] imm32;
  logic             rs1_used, rs2_used, has_target;

  assign fifo_empty = (count_reg == '0);
  assign if_ready_o = (count_reg < CNT_W'(FIFO_DEPTH));
  assign push       = if_valid_i && if_ready_o && !flush_i;

  // An empty FIFO passes the fetch entry straight through so it can stage in the same cycle.
  assign head_inst  = fifo_empty ? if_inst_i : inst_mem[rd_ptr_reg];
  assign head_pc    = fifo_empty ? if_pc_i   : pc_mem[rd_ptr_reg];
  assign head_valid = !fifo_empty || (if_valid_i && !flush_i);

  assign head_opc      = head_inst[6:0];
  assign head_rs1      = head_inst[19:15];
  assign head_rs2      = head_inst[24:20];
  assign rf_rs1_addr_o = head_rs1;
  assign rf_rs2_addr_o = head_rs2;

  always_comb begin
    imm32      = '0;
    rs1_used   = 1'b1;
    rs2_used   = 1'b0;
    has_target = 1'b0;
    case (head_opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm32 = {{20{head_inst[31]}}, head_inst[31:20]};
      OPC_STORE: begin
        imm32    = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
        rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        imm32      = {{19{head_inst[31]}}, head_inst[31], head_inst[7],
                      head_inst[30:25], head_inst[11:8], 1'b0};
        rs2_used   = 1'b1;
        has_target = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32    = {head_inst[31:12], 12'b0};
        rs1_used = 1'b0;
      end
      OPC_JAL: begin
        imm32      = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                      head_inst[20], head_inst[30:21], 1'b0};
        rs1_used   = 1'b0;
        has_target = 1'b1;
      end
      OPC_OP:
        rs2_used = 1'b1;
      default: ;
    endcase
  end

  assign head_imm    = XLEN'(imm32);
  assign head_target = has_target ? (head_pc + head_imm) : '0;

`ifdef ID_WB_BYPASS_EN
  assign head_rs1_val = (head_rs1 == 5'd0) ? '0 :
                        (wb_we_i && wb_rd_i == head_rs1) ? wb_data_i : rf_rs1_data_i;
  assign head_rs2_val = (head_rs2 == 5'd0) ? '0 :
                        (wb_we_i && wb_rd_i == head_rs2) ? wb_data_i : rf_rs2_data_i;
`else
  logic unused_wb;
  assign unused_wb    = ^{wb_we_i, wb_rd_i, wb_data_i};
  assign head_rs1_val = rf_rs1_data_i;
  assign head_rs2_val = rf_rs2_data_i;
`endif

  // Load result is not available until after EX, so a dependent head must wait one bubble.
  assign hazard = id_valid_reg && (id_inst_reg[6:0] == OPC_LOAD) && (id_rd_reg != 5'd0) &&
                  id_ready_i && head_valid &&
                  ((rs1_used && id_rd_reg == head_rs1) || (rs2_used && id_rd_reg == head_rs2));

  assign advance = head_valid && !hazard && (!id_valid_reg || id_ready_i) && !flush_i;
  assign pop     = advance;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) begin
        inst_mem[i] <= if_inst_i;
        pc_mem[i]   <= if_pc_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_reg     <= 1'b0;
      hazard_stall_reg <= 1'b0;
      id_inst_reg      <= '0;
      id_pc_reg        <= '0;
      id_pc_plus_reg   <= '0;
      id_imm_reg       <= '0;
      id_rs1_reg       <= '0;
      id_rs2_reg       <= '0;
      id_rd_reg        <= '0;
      id_target_reg    <= '0;
    end else if (flush_i) begin
      id_valid_reg     <= 1'b0;
      hazard_stall_reg <= 1'b0;
    end else begin
      hazard_stall_reg <= hazard;
      if (advance) begin
        id_valid_reg   <= 1'b1;
        id_inst_reg    <= head_inst;
        id_pc_reg      <= head_pc;
        id_pc_plus_reg <= head_pc + XLEN'(4);
        id_imm_reg     <= head_imm;
        id_rs1_reg     <= head_rs1_val;
        id_rs2_reg     <= head_rs2_val;
        id_rd_reg      <= head_inst[11:7];
        id_target_reg  <= head_target;
      end else if (id_ready_i) begin
        id_valid_reg <= 1'b0;
      end
    end
  end

  assign id_valid_o     = id_valid_reg;
  assign hazard_stall_o = hazard_stall_reg;
  assign id_inst_o      = id_inst_reg;
  assign id_pc_o        = id_pc_reg;
  assign id_pc_plus_o   = id_pc_plus_reg;
  assign id_imm_o       = id_imm_reg;
  assign id_rs1_data_o  = id_rs1_reg;
  assign id_rs2_data_o  = id_rs2_reg;
  assign id_rd_o        = id_rd_reg;
  assign id_target_o    = id_target_reg;

endmodule
